// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority search: first set req bit at or above rr_ptr, wrapping to 0.
module rr_picker #(
  parameter int num_req = 4
) (
  input  logic [num_req-1:0]         req,
  input  logic [$clog2(num_req)-1:0] rr_ptr,
  output logic                       found,
  output logic [$clog2(num_req)-1:0] idx
);
  localparam int IW = $clog2(num_req);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % num_req);
  endfunction

  // Walk the offsets from the far end so the nearest requester overwrites the result last.
  always_comb begin
    logic [IW-1:0] cand_s;
    logic          hit_s;
    found  = 1'b0;
    idx    = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = num_req - 1; i >= 0; i--) begin
      cand_s = wrap_idx(rr_ptr, i);
      hit_s  = req[cand_s];
      found  = found | hit_s;
      idx    = hit_s ? cand_s : idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter on the async FIFO write side: one requester owns the
// write port for up to max_burst words; full stalls the burst without ending it.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int num_req    = DEF_NUM_REQ,
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int max_burst  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            ack,
  input  logic                          full,
  output logic                          wr,
  output logic [data_width-1:0]         wr_data,
  output logic                          grant_valid,
  output logic [$clog2(num_req)-1:0]    grant_id
);
  localparam int IW = $clog2(num_req);
  localparam int BW = $clog2(max_burst) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(max_burst - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(num_req - 1);

  arb_state_e            state_r, state_s;
  logic [IW-1:0]         rr_ptr_r, rr_ptr_s;
  logic [BW-1:0]         beat_cnt_r, beat_cnt_s;
  logic                  grant_valid_r, grant_valid_s;
  logic [IW-1:0]         grant_id_r, grant_id_s;
  logic                  pick_found_s;
  logic [IW-1:0]         pick_idx_s;
  logic                  burst_s, req_g_s, wr_s, last_beat_s;
  logic [num_req-1:0]    ack_s;
  logic [data_width-1:0] wr_data_s;
  logic [data_width-1:0] word_s [num_req];

  for (genvar g = 0; g < num_req; g++) begin : g_word
    assign word_s[g] = req_data[g*data_width +: data_width];
  end

  rr_picker #(
    .num_req (num_req)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s)
  );

  // rst gates the write path directly so nothing leaks out during the reset cycle itself
  assign burst_s     = (state_r == BURST) && !rst;
  assign req_g_s     = req[grant_id_r];
  assign last_beat_s = wr_s && (beat_cnt_r == LAST_BEAT);

  // Write strobe, one-hot ack and write data for the granted requester
  always_comb begin
    wr_s      = 1'b0;
    ack_s     = '0;
    wr_data_s = '0;
    if (burst_s) begin
      wr_data_s = word_s[grant_id_r];
      if (req_g_s && !full) begin
        wr_s              = 1'b1;
        ack_s[grant_id_r] = 1'b1;
      end else begin
        wr_s = 1'b0;
      end
    end else begin
      wr_data_s = '0;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and decide burst exit in BURST
  always_comb begin
    state_s       = state_r;
    rr_ptr_s      = rr_ptr_r;
    beat_cnt_s    = beat_cnt_r;
    grant_valid_s = grant_valid_r;
    grant_id_s    = grant_id_r;
    case (state_r)
      IDLE: begin
        beat_cnt_s = '0;
        if (pick_found_s) begin
          state_s       = BURST;
          grant_valid_s = 1'b1;
          grant_id_s    = pick_idx_s;
        end else begin
          grant_valid_s = 1'b0;
        end
      end
      BURST: begin
        if (last_beat_s || !req_g_s) begin
          state_s       = IDLE;
          grant_valid_s = 1'b0;
          beat_cnt_s    = '0;
          rr_ptr_s      = (grant_id_r == LAST_ID) ? '0 : grant_id_r + IW'(1);
        end else if (wr_s) begin
          beat_cnt_s = beat_cnt_r + BW'(1);
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s       = IDLE;
        grant_valid_s = 1'b0;
        beat_cnt_s    = '0;
      end
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      beat_cnt_r    <= '0;
      grant_valid_r <= 1'b0;
      grant_id_r    <= '0;
    end else begin
      state_r       <= state_s;
      rr_ptr_r      <= rr_ptr_s;
      beat_cnt_r    <= beat_cnt_s;
      grant_valid_r <= grant_valid_s;
      grant_id_r    <= grant_id_s;
    end
  end

  assign wr          = wr_s;
  assign ack         = ack_s;
  assign wr_data     = wr_data_s;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- num_req, 4, number of write requesters (>=2, any value)
- data_width, 8, word width; matches async_fifo data_width
- max_burst, 4, max words per grant (>=1)
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; the async_fifo wr_clk domain
- rst  input  1  synchronous, active-high reset
- req  input  num_req  per-requester write request, held while data pending
- req_data  input  num_req*data_width  flat words; requester i at bits [i*data_width +: data_width]
- ack  output  num_req  one-hot; word of requester i accepted this cycle
- full  input  1  async_fifo full
- wr  output  1  async_fifo write strobe
- wr_data  output  data_width  async_fifo write data
- grant_valid  output  1  a burst grant is held
- grant_id  output  $clog2(num_req)  index of the granted requester

Function
REQ-003 FSM SHALL have two states: IDLE and BURST.
REQ-004 In IDLE with any req bit set, the arbiter SHALL select the first set bit searching upward from rr_ptr, wrapping from num_req-1 to 0.
- Register the winner in grant_id, set grant_valid, enter BURST next cycle.
- No write occurs in the arbitration cycle.
REQ-005 In IDLE with req all zero, the FSM SHALL stay in IDLE with grant_valid=0.
REQ-006 In BURST, wr SHALL equal req[grant_id] AND NOT full, combinationally in the same cycle.
REQ-007 In BURST, ack[grant_id] SHALL equal wr; every other ack bit SHALL be 0.
REQ-008 In BURST, wr_data SHALL equal the grant_id slice of req_data; outside BURST wr_data SHALL be 0.
REQ-009 beat_cnt (width $clog2(max_burst)+1) SHALL increment on each wr and clear on entry to IDLE.
REQ-010 BURST SHALL exit to IDLE at the next edge when either condition holds:
- wr=1 and beat_cnt==max_burst-1 (last beat), or
- req[grant_id]=0 (requester withdrew).
REQ-011 On BURST exit, the arbiter SHALL set:
- rr_ptr = (grant_id+1) mod num_req
- grant_valid = 0
REQ-012 full=1 in BURST SHALL stall without ending the burst: wr=0, ack=0, beat_cnt held.
REQ-013 If req[grant_id] drops while full=1, the burst SHALL end per REQ-010 with no write.
REQ-014 Requests from non-granted requesters SHALL have no effect until the next IDLE cycle.
REQ-015 wr and ack SHALL never assert in IDLE or while rst=1.
REQ-016 With max_burst=1, every grant SHALL carry at most one word.
REQ-017 Each burst SHALL cost max_burst+1 cycles minimum, including the arbitration cycle.

Reset
REQ-018 When rst=1 at a clk edge, the block SHALL set:
- state=IDLE, rr_ptr=0, beat_cnt=0, grant_valid=0, grant_id=0
REQ-019 While rst=1, wr, ack and wr_data SHALL be 0 combinationally, irrespective of req or state.
REQ-020 rst asserted mid-burst SHALL abandon the burst; words already acked remain written and no further word is written.

Structure
REQ-021 Package fifo_arb_pkg SHALL hold:
- FSM state enum (IDLE, BURST)
- default parameter constants
REQ-022 A combinational sub-module rr_picker (inputs req, rr_ptr; outputs found, idx) SHALL implement the rotating priority search.
REQ-023 All state SHALL live in one clocked process on clk; no other clock SHALL be used.

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- Single requester: req=4'b0010, 6 words, full=0 -> idle/grant cycle, 4 writes (ack[1]), idle/grant cycle, 2 writes; write order matches; rr_ptr=2 after the first burst.
- Fairness: req=4'b1111 held, data=8'h10+i for requester i -> grant order 0,1,2,3,0; 4 writes per grant; no requester starved.
- Backpressure: full=1 for 3 cycles after the 2nd beat of requester 2 -> wr=0 for those cycles, burst resumes, total 4 beats, grant_id stays 2.
- Withdrawal: requester 3 drops req after 1 beat -> IDLE next cycle, beat_cnt=0, rr_ptr=0.
- Reset mid-burst: rst=1 after beat 2 -> wr=0 that cycle; state=IDLE, grant_valid=0, rr_ptr=0 next cycle.
- End-to-end: arbiter in front of async_fifo (depth 8), wr_clk:rd_clk=1:3 -> per-requester word order preserved at the read side, no write while full.
